// File: rtl/biriscv_wb_writer_pkg.sv
// ============================================================================
// Module : biriscv_wb_writer_pkg
// Brief  : Shared constants and entry type for the writeback queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package biriscv_wb_writer_pkg;

  localparam int c_wb_depth = 4;
  localparam int c_reg_w    = 5;
  localparam int c_value_w  = 32;
  localparam int c_entry_w  = c_reg_w + c_value_w;

  typedef struct packed {
    logic [c_reg_w-1:0]   rd;
    logic [c_value_w-1:0] value;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/biriscv_wb_queue.sv
// ============================================================================
// Module : biriscv_wb_queue
// Brief  : Circular FIFO accepting up to two entries per cycle, draining one.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module biriscv_wb_queue
  import biriscv_wb_writer_pkg::*;
#(
  parameter int DEPTH = c_wb_depth
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push0_i,
  input  logic [c_entry_w-1:0]         push0_data_i,
  input  logic                         push1_i,
  input  logic [c_entry_w-1:0]         push1_data_i,
  output logic                         ready_o,
  output logic [DEPTH-1:0]             age_valid_o,
  output logic [DEPTH*c_entry_w-1:0]   age_data_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_ready_max = CNT_W'(DEPTH - 2);

  logic [c_entry_w-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  logic                 w_push0;
  logic                 w_push1;
  logic                 w_deq;
  logic [PTR_W-1:0]     w_tail1;

  // Room for two is required so both slots can always be taken together.
  assign ready_o = (r_count <= c_ready_max);
  assign w_push0 = push0_i & ready_o;
  assign w_push1 = push1_i & ready_o;
  assign w_deq   = (r_count != '0);
  assign w_tail1 = r_tail + PTR_W'(w_push0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_deq);
      r_tail  <= r_tail + PTR_W'(w_push0) + PTR_W'(w_push1);
      r_count <= r_count + CNT_W'(w_push0) + CNT_W'(w_push1) - CNT_W'(w_deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push0) begin
      r_mem[r_tail] <= push0_data_i;
    end
    if (w_push1) begin
      r_mem[w_tail1] <= push1_data_i;
    end
  end

  // Slot k of the age-ordered view is k entries behind the head.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] w_idx;
    assign w_idx          = r_head + PTR_W'(k);
    assign age_valid_o[k] = (CNT_W'(k) < r_count);
    assign age_data_o[k*c_entry_w +: c_entry_w] = r_mem[w_idx];
  end

endmodule

`default_nettype wire

// File: rtl/biriscv_wb_writer.sv
// ============================================================================
// Module : biriscv_wb_writer
// Brief  : Dual-slot writeback queue funnelling into one regfile write port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module biriscv_wb_writer
  import biriscv_wb_writer_pkg::*;
#(
  parameter int DEPTH = c_wb_depth
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb0_valid_i,
  input  logic [4:0]  wb0_rd_i,
  input  logic [31:0] wb0_value_i,
  input  logic        wb1_valid_i,
  input  logic [4:0]  wb1_rd_i,
  input  logic [31:0] wb1_value_i,
  output logic        wb_ready_o,
  output logic [4:0]  rd0_o,
  output logic [31:0] rd0_value_o,
  input  logic [4:0]  ra_i,
  input  logic [4:0]  rb_i,
  output logic        ra_fwd_o,
  output logic [31:0] ra_fwd_value_o,
  output logic        rb_fwd_o,
  output logic [31:0] rb_fwd_value_o,
  output logic [31:0] pending_o
);

  logic                       w_push0;
  logic                       w_push1;
  logic [DEPTH-1:0]           w_age_valid;
  logic [DEPTH*c_entry_w-1:0] w_age_data;
  wb_entry_t                  w_head;
  wb_entry_t                  w_e;
  logic [31:0]                w_pending;
  logic                       w_ra_fwd;
  logic [31:0]                w_ra_val;
  logic                       w_rb_fwd;
  logic [31:0]                w_rb_val;

  // x0 writes are dropped here so they never occupy a queue entry.
  assign w_push0 = wb0_valid_i & (wb0_rd_i != '0);
  assign w_push1 = wb1_valid_i & (wb1_rd_i != '0);

  biriscv_wb_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push0_i      (w_push0),
    .push0_data_i ({wb0_rd_i, wb0_value_i}),
    .push1_i      (w_push1),
    .push1_data_i ({wb1_rd_i, wb1_value_i}),
    .ready_o      (wb_ready_o),
    .age_valid_o  (w_age_valid),
    .age_data_o   (w_age_data)
  );

  assign w_head      = wb_entry_t'(w_age_data[c_entry_w-1:0]);
  assign rd0_o       = w_age_valid[0] ? w_head.rd    : '0;
  assign rd0_value_o = w_age_valid[0] ? w_head.value : '0;

  // Walk oldest to youngest so the last hit is the youngest match.
  always_comb begin
    w_e       = '0;
    w_pending = '0;
    w_ra_fwd  = 1'b0;
    w_ra_val  = '0;
    w_rb_fwd  = 1'b0;
    w_rb_val  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_e = wb_entry_t'(w_age_data[k*c_entry_w +: c_entry_w]);
      if (w_age_valid[k]) begin
        w_pending[w_e.rd] = 1'b1;
        if ((ra_i != '0) && (w_e.rd == ra_i)) begin
          w_ra_fwd = 1'b1;
          w_ra_val = w_e.value;
        end
        if ((rb_i != '0) && (w_e.rd == rb_i)) begin
          w_rb_fwd = 1'b1;
          w_rb_val = w_e.value;
        end
      end
    end
    w_pending[0] = 1'b0;
  end

  assign pending_o      = w_pending;
  assign ra_fwd_o       = w_ra_fwd;
  assign ra_fwd_value_o = w_ra_val;
  assign rb_fwd_o       = w_rb_fwd;
  assign rb_fwd_value_o = w_rb_val;

endmodule

`default_nettype wire

// File: tb/tb_biriscv_wb_writer.sv
// ============================================================================
// Module : tb_biriscv_wb_writer
// Brief  : Table vectors plus queue scoreboard for the writeback writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_biriscv_wb_writer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb0_valid_i = 1'b0;
  logic [4:0]  wb0_rd_i = '0;
  logic [31:0] wb0_value_i = '0;
  logic        wb1_valid_i = 1'b0;
  logic [4:0]  wb1_rd_i = '0;
  logic [31:0] wb1_value_i = '0;
  logic [4:0]  ra_i = '0;
  logic [4:0]  rb_i = '0;
  logic        wb_ready_o;
  logic [4:0]  rd0_o;
  logic [31:0] rd0_value_o;
  logic        ra_fwd_o;
  logic [31:0] ra_fwd_value_o;
  logic        rb_fwd_o;
  logic [31:0] rb_fwd_value_o;
  logic [31:0] pending_o;

  always #5 clk_i = ~clk_i;

  biriscv_wb_writer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .wb0_valid_i    (wb0_valid_i),
    .wb0_rd_i       (wb0_rd_i),
    .wb0_value_i    (wb0_value_i),
    .wb1_valid_i    (wb1_valid_i),
    .wb1_rd_i       (wb1_rd_i),
    .wb1_value_i    (wb1_value_i),
    .wb_ready_o     (wb_ready_o),
    .rd0_o          (rd0_o),
    .rd0_value_o    (rd0_value_o),
    .ra_i           (ra_i),
    .rb_i           (rb_i),
    .ra_fwd_o       (ra_fwd_o),
    .ra_fwd_value_o (ra_fwd_value_o),
    .rb_fwd_o       (rb_fwd_o),
    .rb_fwd_value_o (rb_fwd_value_o),
    .pending_o      (pending_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] value;
  } ent_t;

  typedef struct {
    logic        v0;
    logic [4:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  r1;
    logic [31:0] d1;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  e_rd;
    logic [31:0] e_val;
    logic [31:0] e_rafv;
    logic [31:0] e_rbfv;
  } vec_t;

  ent_t exp_q[$];
  vec_t tbl[10];
  int   n_vec  = 0;
  int   n_chk  = 0;
  int   n_miss = 0;
  logic last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] a, input logic [4:0] b);
    wb0_valid_i = v0; wb0_rd_i = r0; wb0_value_i = d0;
    wb1_valid_i = v1; wb1_rd_i = r1; wb1_value_i = d1;
    ra_i = a; rb_i = b;
  endtask

  // Called at the falling edge: compare against current model contents,
  // then advance the model across the coming rising edge.
  task automatic model_step();
    logic        e_ready;
    logic [31:0] pend;
    logic        fa, fb;
    logic [31:0] va, vb;
    e_ready = ((DEPTH - exp_q.size()) >= 2);
    pend = '0; fa = 1'b0; fb = 1'b0; va = '0; vb = '0;
    foreach (exp_q[i]) begin
      pend[exp_q[i].rd] = 1'b1;
      if (ra_i != 0 && exp_q[i].rd == ra_i) begin fa = 1'b1; va = exp_q[i].value; end
      if (rb_i != 0 && exp_q[i].rd == rb_i) begin fb = 1'b1; vb = exp_q[i].value; end
    end
    chk("wb_ready", 32'(wb_ready_o), 32'(e_ready));
    chk("rd0", 32'(rd0_o), (exp_q.size() != 0) ? 32'(exp_q[0].rd) : 32'd0);
    chk("rd0_value", rd0_value_o, (exp_q.size() != 0) ? exp_q[0].value : 32'd0);
    chk("pending", pending_o, pend);
    chk("ra_fwd", 32'(ra_fwd_o), 32'(fa));
    chk("ra_fwd_value", ra_fwd_value_o, va);
    chk("rb_fwd", 32'(rb_fwd_o), 32'(fb));
    chk("rb_fwd_value", rb_fwd_value_o, vb);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    last_acc = e_ready && !rst_i;
    if (last_acc) begin
      if (wb0_valid_i && wb0_rd_i != 0) exp_q.push_back('{wb0_rd_i, wb0_value_i});
      if (wb1_valid_i && wb1_rd_i != 0) exp_q.push_back('{wb1_rd_i, wb1_value_i});
    end
    n_vec++;
  endtask

  task automatic cyc();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seq;
    logic        saw_stall;

    tbl[0] = '{1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0, 32'h0};
    tbl[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5, 32'h11, 32'h11, 32'h0};
    tbl[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd0, 32'h0,  32'h0, 32'h0};
    tbl[3] = '{1'b1, 5'd7, 32'hA,  1'b1, 5'd7, 32'hB, 5'd7, 5'd0, 5'd0, 32'h0,  32'h0, 32'h0};
    tbl[4] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd7, 32'hA,  32'hB, 32'h0};
    tbl[5] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 5'd7, 32'hB,  32'hB, 32'h0};
    tbl[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0,  32'h0, 32'h0};
    tbl[7] = '{1'b1, 5'd0, 32'hFF, 1'b1, 5'd3, 32'h1, 5'd0, 5'd3, 5'd0, 32'h0,  32'h0, 32'h0};
    tbl[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 5'd3, 32'h1,  32'h0, 32'h1};
    tbl[9] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 5'd0, 32'h0,  32'h0, 32'h0};

    // Reset values while held in reset
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd7);
    #2;
    chk("reset_rd0", 32'(rd0_o), 32'd0);
    chk("reset_ready", 32'(wb_ready_o), 32'd1);
    chk("reset_pending", pending_o, 32'd0);
    chk("reset_ra_fwd", 32'(ra_fwd_o), 32'd0);
    chk("reset_rb_fwd", 32'(rb_fwd_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v0, tbl[i].r0, tbl[i].d0, tbl[i].v1, tbl[i].r1, tbl[i].d1, tbl[i].ra, tbl[i].rb);
      @(negedge clk_i);
      chk($sformatf("tbl%0d_rd0", i), 32'(rd0_o), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_val", i), rd0_value_o, tbl[i].e_val);
      chk($sformatf("tbl%0d_rafv", i), ra_fwd_value_o, tbl[i].e_rafv);
      chk($sformatf("tbl%0d_rbfv", i), rb_fwd_value_o, tbl[i].e_rbfv);
      model_step();
      @(posedge clk_i);
      #1;
    end

    // Back-to-back two-slot bursts; producer holds until accepted
    seq = 32'h100;
    saw_stall = 1'b0;
    drive(1'b1, 5'($urandom_range(1, 31)), seq, 1'b1, 5'($urandom_range(1, 31)), seq + 1, 5'd0, 5'd0);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_i);
      if (!wb_ready_o) saw_stall = 1'b1;
      model_step();
      @(posedge clk_i);
      #1;
      if (last_acc) begin
        seq = seq + 2;
        drive(1'b1, 5'($urandom_range(1, 31)), seq, 1'b1, 5'($urandom_range(1, 31)), seq + 1,
              wb0_rd_i, wb1_rd_i);
      end
    end
    chk("burst_stall_seen", 32'(saw_stall), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int c = 0; c < 5; c++) cyc();

    // Reset with three entries queued
    drive(1'b1, 5'd9, 32'h901, 1'b1, 5'd10, 32'h902, 5'd0, 5'd0);
    cyc();
    drive(1'b1, 5'd11, 32'h903, 1'b1, 5'd12, 32'h904, 5'd0, 5'd0);
    cyc();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd12);
    #1;
    chk("prereset_rd0", 32'(rd0_o), 32'd10);
    rst_i = 1'b1;
    #1;
    chk("midreset_rd0", 32'(rd0_o), 32'd0);
    chk("midreset_pending", pending_o, 32'd0);
    chk("midreset_ready", 32'(wb_ready_o), 32'd1);
    chk("midreset_ra_fwd", 32'(ra_fwd_o), 32'd0);
    chk("midreset_rb_fwd", 32'(rb_fwd_o), 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    model_step();
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    for (int c = 0; c < 4; c++) cyc();

    // Random mix including x0 slots and overlapping registers
    for (int c = 0; c < 40; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cyc();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int c = 0; c < 6; c++) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
